// File: rtl/program_scheduler_pkg.sv
// Shared types and helpers for the round-robin program scheduler and its picker.
// State encoding, default index sizing and the zero-quantum clamp live here.
package program_scheduler_pkg;

  localparam int PS_MAX_PROGS = 8;
  localparam int PS_IDX_W     = $clog2(PS_MAX_PROGS);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_START = 3'd2,
    WAIT_DONE  = 3'd3,
    RUN        = 3'd4,
    SELECT     = 3'd5
  } state_t;

  // A zero quantum would never expire, so it runs as a single-cycle slice.
  function automatic logic [31:0] clamp_quantum(input logic [31:0] q);
    return (q == 32'd0) ? 32'd1 : q;
  endfunction

endpackage

// File: rtl/program_scheduler_rr_next_picker.sv
// Round-robin search of the done mask, starting just after the current program.
// The current program is examined last, so it is picked again only when it is the sole survivor.
module rr_next_picker
  import program_scheduler_pkg::*;
#(
  parameter int MAX_PROGS = PS_MAX_PROGS,
  parameter int IDX_W     = PS_IDX_W,
  parameter int NUM_W     = PS_IDX_W + 1
) (
  input  logic [MAX_PROGS-1:0] done_mask,
  input  logic [IDX_W-1:0]     cur,
  input  logic [NUM_W-1:0]     num_programs,
  output logic [IDX_W-1:0]     next_idx,
  output logic                 none_left
);

  int   cand;
  logic found;

  always_comb begin
    next_idx = cur;
    found    = 1'b0;
    cand     = 0;
    for (int i = 1; i <= MAX_PROGS; i++) begin
      cand = int'(cur) + i;
      if (cand >= int'(num_programs)) cand = cand - int'(num_programs);
      if (!found && (i <= int'(num_programs)) && (cand < MAX_PROGS) &&
          !done_mask[IDX_W'(cand)]) begin
        found    = 1'b1;
        next_idx = IDX_W'(cand);
      end
    end
    none_left = !found;
  end

endmodule

// File: rtl/program_scheduler.sv
// Round-robin scheduler in front of the HD-to-RAM loader: issues loads, waits for the copy,
// runs the CPU for one quantum or until halt, and keeps a saved PC per program.
module program_scheduler
  import program_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH    = 12,
  parameter int MAX_PROGS     = PS_MAX_PROGS,
  parameter int QUANTUM_WIDTH = 16,
  parameter int LOAD_TIMEOUT  = 15
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       start,
  input  logic [$clog2(MAX_PROGS):0] num_programs,
  input  logic [QUANTUM_WIDTH-1:0]   quantum,
  input  logic                       carregando,
  input  logic                       proc_halt,
  input  logic [ADDR_WIDTH-1:0]      cpu_pc,
  output logic                       Load_from_HD,
  output logic [ADDR_WIDTH-1:0]      indice_programa,
  output logic                       cpu_run,
  output logic [ADDR_WIDTH-1:0]      resume_pc,
  output logic                       cpu_run_start,
  output logic                       busy,
  output logic                       all_done,
  output logic                       load_error
);

  localparam int IDX_W  = $clog2(MAX_PROGS);
  localparam int NUM_W  = IDX_W + 1;
  localparam int WAIT_W = $clog2(LOAD_TIMEOUT + 1);

  state_t                   state, next_state;
  logic [IDX_W-1:0]         cur;
  logic [NUM_W-1:0]         num_reg;
  logic [QUANTUM_WIDTH-1:0] q_reg;
  logic [QUANTUM_WIDTH-1:0] run_cnt;
  logic [WAIT_W-1:0]        wait_cnt;
  logic [MAX_PROGS-1:0]     done_mask;
  logic [ADDR_WIDTH-1:0]    pc_table [MAX_PROGS];
  logic                     load_err_q;
  logic                     run_first;
  logic [IDX_W-1:0]         pick_idx;
  logic                     none_left;
  logic                     wait_expired;
  logic                     run_last;

  rr_next_picker #(
    .MAX_PROGS(MAX_PROGS),
    .IDX_W    (IDX_W),
    .NUM_W    (NUM_W)
  ) u_picker (
    .done_mask   (done_mask),
    .cur         (cur),
    .num_programs(num_reg),
    .next_idx    (pick_idx),
    .none_left   (none_left)
  );

  assign wait_expired = (wait_cnt == WAIT_W'(LOAD_TIMEOUT - 1));
  assign run_last     = (run_cnt == QUANTUM_WIDTH'(1));

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (start) next_state = ISSUE;
      ISSUE:      if (!carregando) next_state = WAIT_START;
      WAIT_START: begin
        if (carregando)        next_state = WAIT_DONE;
        else if (wait_expired) next_state = IDLE;
      end
      WAIT_DONE:  if (!carregando) next_state = RUN;
      RUN:        if (proc_halt || run_last) next_state = SELECT;
      SELECT:     next_state = none_left ? IDLE : ISSUE;
      default:    next_state = IDLE;
    endcase
  end

  // The loader ignores requests while busy, so the pulse is held back until carregando drops.
  always_comb begin
    Load_from_HD  = 1'b0;
    cpu_run       = 1'b0;
    cpu_run_start = 1'b0;
    busy          = 1'b1;
    all_done      = 1'b0;
    case (state)
      IDLE:    busy = 1'b0;
      ISSUE:   Load_from_HD = !carregando;
      RUN: begin
        cpu_run       = 1'b1;
        cpu_run_start = run_first;
      end
      SELECT:  all_done = none_left;
      default: ;
    endcase
  end

  assign indice_programa = ADDR_WIDTH'(cur);
  assign resume_pc       = cpu_run_start ? pc_table[cur] : '0;
  assign load_error      = load_err_q;

  // Halt wins over quantum expiry, so a program that halts on its last cycle keeps its old PC.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cur        <= '0;
      num_reg    <= '0;
      q_reg      <= '0;
      run_cnt    <= '0;
      wait_cnt   <= '0;
      done_mask  <= '0;
      load_err_q <= 1'b0;
      run_first  <= 1'b0;
      for (int i = 0; i < MAX_PROGS; i++) pc_table[i] <= '0;
    end else begin
      run_first <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            num_reg    <= num_programs;
            q_reg      <= QUANTUM_WIDTH'(clamp_quantum(32'(quantum)));
            cur        <= '0;
            done_mask  <= '0;
            load_err_q <= 1'b0;
            for (int i = 0; i < MAX_PROGS; i++) pc_table[i] <= '0;
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT_START: begin
          if (!carregando) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_expired) load_err_q <= 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!carregando) begin
            run_cnt   <= q_reg;
            run_first <= 1'b1;
          end
        end
        RUN: begin
          if (proc_halt)     done_mask[cur] <= 1'b1;
          else if (run_last) pc_table[cur]  <= cpu_pc;
          else               run_cnt        <= run_cnt - 1'b1;
        end
        SELECT: if (!none_left) cur <= pick_idx;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_scheduler.sv
// Directed bench for program_scheduler with a simple behavioural loader model.
// Expected indices, PCs and slice lengths below are worked out by hand from the schedule.
module tb_program_scheduler;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        start;
  logic [3:0]  num_programs;
  logic [15:0] quantum;
  logic        carregando = 1'b0;
  logic        proc_halt;
  logic [11:0] cpu_pc;
  logic        Load_from_HD;
  logic [11:0] indice_programa;
  logic        cpu_run;
  logic [11:0] resume_pc;
  logic        cpu_run_start;
  logic        busy;
  logic        all_done;
  logic        load_error;

  int n_checks = 0;
  int n_fail   = 0;
  int load_hold = 700;
  bit loader_enable = 1'b1;
  int hold_left = 0;
  int all_done_count = 0;

  program_scheduler #(
    .ADDR_WIDTH   (12),
    .MAX_PROGS    (8),
    .QUANTUM_WIDTH(16),
    .LOAD_TIMEOUT (15)
  ) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .start          (start),
    .num_programs   (num_programs),
    .quantum        (quantum),
    .carregando     (carregando),
    .proc_halt      (proc_halt),
    .cpu_pc         (cpu_pc),
    .Load_from_HD   (Load_from_HD),
    .indice_programa(indice_programa),
    .cpu_run        (cpu_run),
    .resume_pc      (resume_pc),
    .cpu_run_start  (cpu_run_start),
    .busy           (busy),
    .all_done       (all_done),
    .load_error     (load_error)
  );

  always #5 Clock = ~Clock;

  // Loader: busy from the edge after an accepted request, for load_hold cycles.
  always @(posedge Clock) begin
    if (Reset) begin
      carregando <= 1'b0;
      hold_left  <= 0;
    end else if (carregando) begin
      if (hold_left <= 1) carregando <= 1'b0;
      else                hold_left  <= hold_left - 1;
    end else if (Load_from_HD && loader_enable) begin
      carregando <= 1'b1;
      hold_left  <= load_hold;
    end
  end

  always @(posedge Clock) begin
    if (!Reset && all_done) all_done_count <= all_done_count + 1;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached before end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] num, input logic [15:0] q);
    @(negedge Clock);
    num_programs = num;
    quantum      = q;
    start        = 1'b1;
    @(negedge Clock);
    start = 1'b0;
  endtask

  task automatic waitLoad(input string tag, input int limit);
    int k = 0;
    while (!Load_from_HD && k < limit) begin
      @(negedge Clock);
      k++;
    end
    checkOutput({tag, "_load"}, 32'(Load_from_HD), 1);
  endtask

  task automatic waitRunStart(input string tag, input int limit);
    int k = 0;
    while (!cpu_run_start && k < limit) begin
      @(negedge Clock);
      k++;
    end
    checkOutput({tag, "_run_start"}, 32'(cpu_run_start), 1);
  endtask

  task automatic runSlice(input int halt_at, output int len);
    len = 0;
    while (cpu_run && len < 1000) begin
      len++;
      if (len == halt_at) proc_halt = 1'b1;
      @(negedge Clock);
      proc_halt = 1'b0;
    end
  endtask

  task automatic doSlice(input string tag, input int exp_idx, input int halt_at,
                         input int exp_len, input logic [11:0] exp_resume,
                         input logic [11:0] pc_val);
    int len;
    waitLoad(tag, 1000);
    checkOutput({tag, "_idx"}, 32'(indice_programa), exp_idx);
    waitRunStart(tag, 1000);
    checkOutput({tag, "_resume"}, 32'(resume_pc), 32'(exp_resume));
    cpu_pc = pc_val;
    runSlice(halt_at, len);
    checkOutput({tag, "_len"}, len, exp_len);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_load"},   32'(Load_from_HD), 0);
    checkOutput({tag, "_idx"},    32'(indice_programa), 0);
    checkOutput({tag, "_run"},    32'(cpu_run), 0);
    checkOutput({tag, "_resume"}, 32'(resume_pc), 0);
    checkOutput({tag, "_rstart"}, 32'(cpu_run_start), 0);
    checkOutput({tag, "_busy"},   32'(busy), 0);
    checkOutput({tag, "_alldone"},32'(all_done), 0);
    checkOutput({tag, "_lerr"},   32'(load_error), 0);
  endtask

  initial begin
    int k;
    int len;
    int done_before;
    Reset = 1'b1; start = 1'b0; num_programs = '0; quantum = '0;
    proc_halt = 1'b0; cpu_pc = '0;
    repeat (3) @(negedge Clock);
    checkAllZero("rst");
    Reset = 1'b0;

    // Two programs, quantum 100, slow loader.
    $display("[TB] two programs, quantum 100, 700-cycle loads");
    load_hold = 700;
    cpu_pc = 12'h2A5;
    applyStimulus(4'd2, 16'd100);
    checkOutput("b_p0_load", 32'(Load_from_HD), 1);
    checkOutput("b_p0_idx", 32'(indice_programa), 0);
    k = 0;
    while (!carregando && k < 10) begin @(negedge Clock); k++; end
    checkOutput("b_car_rise", 32'(carregando), 1);
    k = 0;
    while (carregando && k < 800) begin @(negedge Clock); k++; end
    checkOutput("b_car_fall", 32'(carregando), 0);
    checkOutput("b_no_run_yet", 32'(cpu_run_start), 0);
    @(negedge Clock);
    checkOutput("b_p0_rstart", 32'(cpu_run_start), 1);
    checkOutput("b_p0_resume", 32'(resume_pc), 0);
    runSlice(0, len);
    checkOutput("b_p0_len", len, 100);
    checkOutput("b_sel_noload", 32'(Load_from_HD), 0);
    checkOutput("b_sel_busy", 32'(busy), 1);
    doSlice("b_p1", 1, 0, 100, 12'h000, 12'h0F0);
    waitLoad("b_p0b", 1000);
    checkOutput("b_p0b_idx", 32'(indice_programa), 0);
    waitRunStart("b_p0b", 1000);
    checkOutput("b_p0b_resume", 32'(resume_pc), 32'h2A5);
    repeat (10) @(negedge Clock);
    checkOutput("b_mid_run", 32'(cpu_run), 1);
    Reset = 1'b1;
    @(negedge Clock);
    checkAllZero("b_midrst");
    Reset = 1'b0;

    // Three programs, program 1 halts early; last one halts on the expiry cycle.
    $display("[TB] three programs, quantum 4, halts");
    load_hold = 3;
    done_before = all_done_count;
    applyStimulus(4'd3, 16'd4);
    doSlice("c_s1", 0, 0, 4, 12'h000, 12'h101);
    doSlice("c_s2", 1, 2, 2, 12'h000, 12'h202);
    doSlice("c_s3", 2, 0, 4, 12'h000, 12'h303);
    doSlice("c_s4", 0, 0, 4, 12'h101, 12'h111);
    doSlice("c_s5", 2, 1, 1, 12'h303, 12'h3FF);
    doSlice("c_s6", 0, 0, 4, 12'h111, 12'h222);
    doSlice("c_s7", 0, 4, 4, 12'h222, 12'h999);
    checkOutput("c_all_done", 32'(all_done), 1);
    checkOutput("c_busy_sel", 32'(busy), 1);
    @(negedge Clock);
    checkOutput("c_all_done_end", 32'(all_done), 0);
    checkOutput("c_idle", 32'(busy), 0);
    repeat (5) @(negedge Clock);
    checkOutput("c_all_done_once", all_done_count - done_before, 1);

    // Loader never answers.
    $display("[TB] load timeout");
    loader_enable = 1'b0;
    applyStimulus(4'd1, 16'd5);
    checkOutput("d_load", 32'(Load_from_HD), 1);
    repeat (15) @(negedge Clock);
    checkOutput("d_err_pending", 32'(load_error), 0);
    checkOutput("d_busy_wait", 32'(busy), 1);
    @(negedge Clock);
    checkOutput("d_err_set", 32'(load_error), 1);
    checkOutput("d_idle", 32'(busy), 0);
    repeat (3) @(negedge Clock);
    checkOutput("d_err_sticky", 32'(load_error), 1);

    // Restart clears the error; quantum 0 gives one-cycle slices.
    $display("[TB] restart with quantum 0");
    loader_enable = 1'b1;
    applyStimulus(4'd1, 16'd0);
    checkOutput("e_err_cleared", 32'(load_error), 0);
    doSlice("e_s1", 0, 0, 1, 12'h000, 12'h0AB);
    doSlice("e_s2", 0, 1, 1, 12'h0AB, 12'h0CD);
    checkOutput("e_all_done", 32'(all_done), 1);
    @(negedge Clock);
    checkOutput("e_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
